// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction-memory read port between CPU fetch and debug readback.
// Build option IMEM_ARB_RR_EN selects round-robin arbitration instead of CPU priority with a starvation guard.
module imem_arbiter #(
  parameter int NB_ADDR      = 32,
  parameter int NB_WORD      = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req_valid,
  input  logic [NB_ADDR-1:0] cpu_req_pc,
  output logic               cpu_req_ready,
  input  logic               cpu_flush,
  output logic               cpu_rsp_valid,
  output logic [NB_WORD-1:0] cpu_rsp_instr,
  input  logic               dbg_req_valid,
  input  logic [NB_ADDR-1:0] dbg_req_addr,
  output logic               dbg_req_ready,
  output logic               dbg_rsp_valid,
  output logic [NB_WORD-1:0] dbg_rsp_data,
  output logic [NB_ADDR-1:0] mem_pc,
  input  logic [NB_WORD-1:0] mem_instruction,
  output logic               arb_state
);

  // Handshake: a request transfers in any cycle where valid and ready are both high. Ready is a
  // combinational function of both valids and arbiter state; requesters hold valid/address until taken.
  logic gnt_cpu;
  logic gnt_dbg;

`ifdef IMEM_ARB_RR_EN
  logic last_owner;  // 1 = dbg

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= 1'b1;
    end else if (gnt_dbg) begin
      last_owner <= 1'b1;
    end else if (gnt_cpu) begin
      last_owner <= 1'b0;
    end
  end

  always_comb begin
    gnt_dbg = 1'b0;
    gnt_cpu = 1'b0;
    if (!rst) begin
      gnt_dbg = dbg_req_valid && (!cpu_req_valid || !last_owner);
      gnt_cpu = cpu_req_valid && !gnt_dbg;
    end
  end

  assign arb_state = 1'b0;
`else
  typedef enum logic {CPU_PRI = 1'b0, DBG_FORCE = 1'b1} arb_state_t;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  arb_state_t state;
  arb_state_t state_next;
  logic [7:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CPU_PRI;
      starve_cnt <= 8'd0;
    end else begin
      state <= state_next;
      if (dbg_req_valid && !gnt_dbg) begin
        starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= 8'd0;
      end
    end
  end

  // DBG_FORCE is entered exactly when the starve counter is about to reach the limit.
  always_comb begin
    state_next = CPU_PRI;
    case (state)
      CPU_PRI: begin
        if (dbg_req_valid && !gnt_dbg && starve_cnt == LIMIT - 8'd1) begin
          state_next = DBG_FORCE;
        end
      end
      DBG_FORCE: state_next = CPU_PRI;
      default:   state_next = CPU_PRI;
    endcase
  end

  always_comb begin
    gnt_dbg = 1'b0;
    gnt_cpu = 1'b0;
    if (!rst) begin
      gnt_dbg = dbg_req_valid && (!cpu_req_valid || state == DBG_FORCE);
      gnt_cpu = cpu_req_valid && !gnt_dbg;
    end
  end

  assign arb_state = (state == DBG_FORCE);
`endif

  assign cpu_req_ready = gnt_cpu;
  assign dbg_req_ready = gnt_dbg;

  // Tag pipe: stage k is live k cycles after acceptance; stage MEM_LAT lines up with mem_instruction.
  logic [MEM_LAT:1] tag_v;
  logic [MEM_LAT:1] tag_own;  // 1 = dbg
  logic             ret_cpu;
  logic             ret_dbg;

  assign ret_cpu = tag_v[MEM_LAT] && !tag_own[MEM_LAT] && !cpu_flush;
  assign ret_dbg = tag_v[MEM_LAT] && tag_own[MEM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v         <= '0;
      tag_own       <= '0;
      cpu_rsp_valid <= 1'b0;
      dbg_rsp_valid <= 1'b0;
      cpu_rsp_instr <= '0;
      dbg_rsp_data  <= '0;
      mem_pc        <= '0;
    end else begin
      tag_v[1]   <= gnt_cpu || gnt_dbg;
      tag_own[1] <= gnt_dbg;
      for (int k = 2; k <= MEM_LAT; k++) begin
        tag_v[k]   <= tag_v[k-1] && !(cpu_flush && !tag_own[k-1]);
        tag_own[k] <= tag_own[k-1];
      end
      cpu_rsp_valid <= ret_cpu;
      dbg_rsp_valid <= ret_dbg;
      if (ret_cpu) cpu_rsp_instr <= mem_instruction;
      if (ret_dbg) dbg_rsp_data  <= mem_instruction;
      if (gnt_dbg) begin
        mem_pc <= dbg_req_addr;
      end else if (gnt_cpu) begin
        mem_pc <= cpu_req_pc;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: two instances (MEM_LAT 1 and 3) share one stimulus stream and are
// checked against an arbitration model plus a response scoreboard.
module tb_imem_arbiter;

  localparam int LIMIT = 8;
  localparam int W     = 50;  // {inst, owner(1=dbg), due_cycle[15:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic [31:0] cpu_req_pc;
  logic        cpu_flush;
  logic        dbg_req_valid;
  logic [31:0] dbg_req_addr;

  logic [1:0]  cpu_req_ready;
  logic [1:0]  dbg_req_ready;
  logic [1:0]  cpu_rsp_valid;
  logic [1:0]  dbg_rsp_valid;
  logic [1:0]  arb_state;
  logic [31:0] cpu_rsp_instr [2];
  logic [31:0] dbg_rsp_data  [2];
  logic [31:0] mem_pc        [2];
  logic [31:0] mem_instruction [2];
  logic [31:0] pc_d1;
  logic [31:0] pc_d2;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int starve = 0;
  logic last_dbg = 1'b1;
  logic exp_gnt_cpu = 1'b0;
  logic exp_gnt_dbg = 1'b0;
  logic [31:0] exp_mem_pc = '0;
  logic post_rst = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  // Memory models: instance 0 reads combinationally, instance 1 adds two register stages.
  assign mem_instruction[0] = word(mem_pc[0]);
  always @(posedge clk) begin
    pc_d1 <= mem_pc[1];
    pc_d2 <= pc_d1;
  end
  assign mem_instruction[1] = word(pc_d2);

  imem_arbiter #(.NB_ADDR(32), .NB_WORD(32), .MEM_LAT(1), .STARVE_LIMIT(LIMIT)) u_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_pc(cpu_req_pc), .cpu_req_ready(cpu_req_ready[0]),
    .cpu_flush(cpu_flush), .cpu_rsp_valid(cpu_rsp_valid[0]), .cpu_rsp_instr(cpu_rsp_instr[0]),
    .dbg_req_valid(dbg_req_valid), .dbg_req_addr(dbg_req_addr), .dbg_req_ready(dbg_req_ready[0]),
    .dbg_rsp_valid(dbg_rsp_valid[0]), .dbg_rsp_data(dbg_rsp_data[0]),
    .mem_pc(mem_pc[0]), .mem_instruction(mem_instruction[0]), .arb_state(arb_state[0])
  );

  imem_arbiter #(.NB_ADDR(32), .NB_WORD(32), .MEM_LAT(3), .STARVE_LIMIT(LIMIT)) u_lat3 (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_pc(cpu_req_pc), .cpu_req_ready(cpu_req_ready[1]),
    .cpu_flush(cpu_flush), .cpu_rsp_valid(cpu_rsp_valid[1]), .cpu_rsp_instr(cpu_rsp_instr[1]),
    .dbg_req_valid(dbg_req_valid), .dbg_req_addr(dbg_req_addr), .dbg_req_ready(dbg_req_ready[1]),
    .dbg_rsp_valid(dbg_rsp_valid[1]), .dbg_rsp_data(dbg_rsp_data[1]),
    .mem_pc(mem_pc[1]), .mem_instruction(mem_instruction[1]), .arb_state(arb_state[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Pops the scoreboard entry due this cycle for (inst, owner) and compares valid/data.
  task automatic chk_rsp(input int i, input logic own, input logic v, input logic [31:0] d);
    int idx = -1;
    string nm = own ? "dbg" : "cpu";
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k][49] == 1'(i) && exp_q[k][48] == own) begin
        idx = k;
        break;
      end
    end
    if (idx >= 0 && exp_q[idx][47:32] <= 16'(cyc)) begin
      check($sformatf("%s_rsp_valid/%0d", nm, i), {31'd0, v}, 32'd1);
      check($sformatf("%s_rsp_data/%0d", nm, i), d, exp_q[idx][31:0]);
      exp_q.delete(idx);
    end else begin
      check($sformatf("%s_rsp_valid/%0d", nm, i), {31'd0, v}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rst_cpu_ready/%0d", i), {31'd0, cpu_req_ready[i]}, 32'd0);
        check($sformatf("rst_dbg_ready/%0d", i), {31'd0, dbg_req_ready[i]}, 32'd0);
      end
      exp_q.delete();
      starve      = 0;
      last_dbg    = 1'b1;
      exp_mem_pc  = '0;
      exp_gnt_cpu = 1'b0;
      exp_gnt_dbg = 1'b0;
      post_rst    = 1'b1;
    end else begin
`ifdef IMEM_ARB_RR_EN
      exp_gnt_dbg = dbg_req_valid && (!cpu_req_valid || !last_dbg);
`else
      exp_gnt_dbg = dbg_req_valid && (!cpu_req_valid || starve == LIMIT);
`endif
      exp_gnt_cpu = cpu_req_valid && !exp_gnt_dbg;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cpu_ready/%0d", i), {31'd0, cpu_req_ready[i]}, {31'd0, exp_gnt_cpu});
        check($sformatf("dbg_ready/%0d", i), {31'd0, dbg_req_ready[i]}, {31'd0, exp_gnt_dbg});
`ifdef IMEM_ARB_RR_EN
        check($sformatf("arb_state/%0d", i), {31'd0, arb_state[i]}, 32'd0);
`else
        check($sformatf("arb_state/%0d", i), {31'd0, arb_state[i]}, (starve == LIMIT) ? 32'd1 : 32'd0);
`endif
        check($sformatf("mem_pc/%0d", i), mem_pc[i], exp_mem_pc);
        if (post_rst) begin
          check($sformatf("rst_cpu_instr/%0d", i), cpu_rsp_instr[i], 32'd0);
          check($sformatf("rst_dbg_data/%0d", i), dbg_rsp_data[i], 32'd0);
        end
        chk_rsp(i, 1'b0, cpu_rsp_valid[i], cpu_rsp_instr[i]);
        chk_rsp(i, 1'b1, dbg_rsp_valid[i], dbg_rsp_data[i]);
      end
      post_rst = 1'b0;
      if (cpu_flush) begin
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
          if (!exp_q[k][48] && exp_q[k][47:32] > 16'(cyc)) exp_q.delete(k);
        end
      end
      if (exp_gnt_dbg) begin
        exp_q.push_back({1'b0, 1'b1, 16'(cyc + 2), word(dbg_req_addr)});
        exp_q.push_back({1'b1, 1'b1, 16'(cyc + 4), word(dbg_req_addr)});
        exp_mem_pc = dbg_req_addr;
        last_dbg   = 1'b1;
      end else if (exp_gnt_cpu) begin
        exp_q.push_back({1'b0, 1'b0, 16'(cyc + 2), word(cpu_req_pc)});
        exp_q.push_back({1'b1, 1'b0, 16'(cyc + 4), word(cpu_req_pc)});
        exp_mem_pc = cpu_req_pc;
        last_dbg   = 1'b0;
      end
      if (dbg_req_valid && !exp_gnt_dbg) starve = starve + 1;
      else starve = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt_cpu;
  int cnt_dbg;

  initial begin
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_pc = '0; cpu_flush = 1'b0;
    dbg_req_valid = 1'b0; dbg_req_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // back-to-back CPU fetches
    cpu_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_req_pc = 32'(4 * i);
      tick();
    end
    cpu_req_valid = 1'b0;
    repeat (6) tick();

    // lone debug read
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h100;
    tick();
    dbg_req_valid = 1'b0;
    repeat (6) tick();

    // continuous contention
    cnt_cpu = 0; cnt_dbg = 0;
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h200;
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h300;
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      #1;
      cnt_cpu += int'(cpu_req_ready[0]) + int'(cpu_req_ready[1]);
      cnt_dbg += int'(dbg_req_ready[0]) + int'(dbg_req_ready[1]);
      @(posedge clk);
      #1;
      if (exp_gnt_cpu) cpu_req_pc += 32'd4;
      if (exp_gnt_dbg) dbg_req_addr += 32'd4;
    end
`ifdef IMEM_ARB_RR_EN
    check("contend_cpu_grants", 32'(cnt_cpu), 32'd18);
    check("contend_dbg_grants", 32'(cnt_dbg), 32'd18);
`else
    check("contend_cpu_grants", 32'(cnt_cpu), 32'd32);
    check("contend_dbg_grants", 32'(cnt_dbg), 32'd4);
`endif
    cpu_req_valid = 1'b0; dbg_req_valid = 1'b0;
    repeat (6) tick();

    // flush with a new request in the same cycle
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h40;
    tick();
    cpu_req_pc = 32'h44;
    tick();
    cpu_req_pc = 32'h48; cpu_flush = 1'b1;
    tick();
    cpu_req_valid = 1'b0; cpu_flush = 1'b0;
    repeat (8) tick();

    // flush while a debug read is in flight
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h104;
    tick();
    dbg_req_valid = 1'b0; cpu_flush = 1'b1;
    tick();
    cpu_flush = 1'b0;
    repeat (6) tick();

    // reset with reads in flight, then a normal read
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h80;
    tick();
    cpu_req_pc = 32'h84;
    tick();
    cpu_req_valid = 1'b0; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    cpu_req_valid = 1'b1; cpu_req_pc = 32'h88;
    tick();
    cpu_req_valid = 1'b0;
    repeat (6) tick();

    // random traffic, requests held until granted
    for (int n = 0; n < 400; n++) begin
      if (!cpu_req_valid || exp_gnt_cpu) begin
        cpu_req_valid = 1'($urandom_range(0, 1));
        cpu_req_pc    = 32'($urandom_range(0, 1023)) << 2;
      end
      if (!dbg_req_valid || exp_gnt_dbg) begin
        dbg_req_valid = ($urandom_range(0, 2) != 0);
        dbg_req_addr  = 32'($urandom_range(0, 1023)) << 2;
      end
      cpu_flush = ($urandom_range(0, 7) == 0);
      tick();
    end
    cpu_req_valid = 1'b0; dbg_req_valid = 1'b0; cpu_flush = 1'b0;
    repeat (8) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
